// File: rtl/deskew_pkg.sv
// Shared types for the multi-lane PCS receive deskew block.
// The tagged block carries a lane's payload together with its AM marker bit.
package deskew_pkg;

  localparam int DEF_LANE_N  = 4;
  localparam int DEF_BLOCK_W = 66;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED
  } state_e;

  typedef struct packed {
    logic                   am;
    logic [DEF_BLOCK_W-1:0] data;
  } tag_blk_t;

endpackage

// File: rtl/deskew_lane_buf.sv
// One lane of the deskew: tagged shift buffer, AM-relative skew counter,
// seen flag and the output tap selected by the latched skew.
module deskew_lane_buf
  import deskew_pkg::*;
#(
  parameter int DEPTH = 27,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   am_i,
  input  logic [DEF_BLOCK_W-1:0] data_i,
  input  logic                   srch_i,
  input  logic                   clr_i,
  input  logic                   latch_i,
  output logic                   seenNext_o,
  output logic                   ovf_o,
  output logic [CNT_W-1:0]       skew_o,
  output logic                   tapAm_o,
  output logic [DEF_BLOCK_W-1:0] tapData_o
);

  tag_blk_t         buff_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] skew_q;
  logic             seen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buff_q[i] <= '0;
    end else if (valid_i) begin
      buff_q[0] <= {am_i, data_i};
      for (int i = 1; i < DEPTH; i++) buff_q[i] <= buff_q[i-1];
    end
  end

  // The count on the cycle the final lane is seen is already the tap index.
  assign cnt_d      = am_i ? '0 : cnt_q + 1'b1;
  assign seenNext_o = seen_q | am_i;
  assign ovf_o      = seen_q & ~am_i & (cnt_q == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else if (srch_i) begin
      seen_q <= seenNext_o;
      if (seenNext_o) cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) skew_q <= '0;
    else if (latch_i) skew_q <= cnt_d;
  end

  assign skew_o    = skew_q;
  assign tapAm_o   = buff_q[skew_q].am;
  assign tapData_o = buff_q[skew_q].data;

endmodule

// File: rtl/deskew_rx.sv
// Multi-lane receive deskew: measures AM skew across lanes, realigns them onto
// the latest lane and supervises AM coincidence while locked.
module deskew_rx
  import deskew_pkg::*;
#(
  parameter int LANE_N           = DEF_LANE_N,
  parameter int BLOCK_W          = DEF_BLOCK_W,
  parameter int MAX_SKEW_BLOCK_N = 27,
  parameter int AM_PERIOD        = 16384,
  parameter int SKEW_CNT_W       = $clog2(MAX_SKEW_BLOCK_N + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_i,
  input  logic [LANE_N-1:0]            am_lock_i,
  input  logic [LANE_N-1:0]            am_v_i,
  input  logic [LANE_N*BLOCK_W-1:0]    data_i,
  output logic                         valid_o,
  output logic                         am_v_o,
  output logic [LANE_N*BLOCK_W-1:0]    data_o,
  output logic                         deskew_lock_o,
  output logic [LANE_N*SKEW_CNT_W-1:0] skew_o,
  output logic                         skew_err_o
);

  localparam int PER_W = $clog2(AM_PERIOD);

  state_e             state_q, state_d;
  logic               valid_q;
  logic               err_q, err_d;
  logic               clr, latch, srch;
  logic [PER_W-1:0]   per_q;
  logic [LANE_N-1:0]  seenNext, ovf, tapAm;
  logic [BLOCK_W-1:0] tapData [LANE_N];
  logic               allLock, ovfAny, seenAll;
  logic               outValid, tagAll, tagAny, misalign;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    deskew_lane_buf #(
      .DEPTH (MAX_SKEW_BLOCK_N),
      .CNT_W (SKEW_CNT_W)
    ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .valid_i    (valid_i),
      .am_i       (am_v_i[l]),
      .data_i     (data_i[l*BLOCK_W +: BLOCK_W]),
      .srch_i     (srch),
      .clr_i      (clr),
      .latch_i    (latch),
      .seenNext_o (seenNext[l]),
      .ovf_o      (ovf[l]),
      .skew_o     (skew_o[l*SKEW_CNT_W +: SKEW_CNT_W]),
      .tapAm_o    (tapAm[l]),
      .tapData_o  (tapData[l])
    );
    assign data_o[l*BLOCK_W +: BLOCK_W] = tapData[l];
  end

  assign allLock  = &am_lock_i;
  assign srch     = (state_q == SEARCH) & valid_i;
  assign ovfAny   = srch & (|ovf);
  assign seenAll  = srch & (&seenNext);
  assign outValid = valid_q & (state_q == LOCKED);
  assign tagAll   = &tapAm;
  assign tagAny   = |tapAm;
  assign misalign = outValid & ((tagAny & ~tagAll) |
                                (~tagAll & (per_q == PER_W'(AM_PERIOD - 1))));

  // Lock loss overrides every other transition but keeps any error pulse.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    clr     = (state_q != SEARCH);
    case (state_q)
      IDLE:    if (allLock) state_d = SEARCH;
      SEARCH: begin
        if (ovfAny) begin
          err_d = 1'b1;
          clr   = 1'b1;
        end else if (seenAll) begin
          latch   = 1'b1;
          clr     = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (misalign) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!allLock) begin
      state_d = IDLE;
      latch   = 1'b0;
      clr     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_i;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) per_q <= '0;
    else if (state_q != LOCKED) per_q <= '0;
    else if (outValid) per_q <= tagAll ? '0 : per_q + 1'b1;
  end

  assign valid_o       = outValid;
  assign am_v_o        = outValid & tagAll;
  assign deskew_lock_o = (state_q == LOCKED);
  assign skew_err_o    = err_q;

endmodule

// File: tb/tb_deskew_rx.sv
// Randomized bench for deskew_rx: lanes carry AMs at per-lane offsets and the
// expected output is taken from the per-lane send history at the skew implied by those offsets.
module tb_deskew_rx;

  localparam int AMP = 64;
  localparam int AM_POS = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_i;
  logic [3:0]   am_lock_i;
  logic [3:0]   am_v_i;
  logic [263:0] data_i;
  logic         valid_o;
  logic         am_v_o;
  logic [263:0] data_o;
  logic         deskew_lock_o;
  logic [19:0]  skew_o;
  logic         skew_err_o;

  int total = 0;
  int bad = 0;
  int offA[4];
  int offB[4];
  int expD[4];
  int switchV;
  int vcnt;
  logic [65:0] hist [4][1024];

  deskew_rx #(.AM_PERIOD(AMP)) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .am_lock_i     (am_lock_i),
    .am_v_i        (am_v_i),
    .data_i        (data_i),
    .valid_o       (valid_o),
    .am_v_o        (am_v_o),
    .data_o        (data_o),
    .deskew_lock_o (deskew_lock_o),
    .skew_o        (skew_o),
    .skew_err_o    (skew_err_o)
  );

  always #5 clk = ~clk;

  // Lane position relative to its AM grid; the offset plan may change at switchV.
  function automatic int posOf(int l, int v);
    return v - ((v < switchV) ? offA[l] : offB[l]);
  endfunction

  function automatic logic isAm(int l, int v);
    int p = posOf(l, v);
    return (((p % AMP) + AMP) % AMP) == AM_POS;
  endfunction

  function automatic void computeD(bit useB);
    int m = 0;
    for (int l = 0; l < 4; l++) begin
      int o = useB ? offB[l] : offA[l];
      if (o > m) m = o;
    end
    for (int l = 0; l < 4; l++) expD[l] = m - (useB ? offB[l] : offA[l]);
  endfunction

  function automatic logic [263:0] expData();
    logic [263:0] r;
    for (int l = 0; l < 4; l++) r[l*66 +: 66] = hist[l][vcnt-1-expD[l]];
    return r;
  endfunction

  function automatic logic expAm();
    logic r = 1'b1;
    for (int l = 0; l < 4; l++) r &= isAm(l, vcnt-1-expD[l]);
    return r;
  endfunction

  function automatic logic [19:0] expSkew();
    logic [19:0] r;
    for (int l = 0; l < 4; l++) r[l*5 +: 5] = 5'(expD[l]);
    return r;
  endfunction

  task automatic applyStimulus(input bit vld);
    logic [65:0] blk;
    valid_i = vld;
    for (int l = 0; l < 4; l++) begin
      if (vld) begin
        blk = {l[1:0], 32'(posOf(l, vcnt)), 32'($urandom())};
        hist[l][vcnt] = blk;
        am_v_i[l] = isAm(l, vcnt);
        data_i[l*66 +: 66] = blk;
      end else begin
        am_v_i[l] = 1'($urandom());
        data_i[l*66 +: 66] = {2'b11, 32'($urandom()), 32'($urandom())};
      end
    end
    if (vld) vcnt++;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    am_lock_i = 4'hF;
    valid_i = 1'b0;
    am_v_i = '0;
    data_i = '0;
    vcnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    reset = 1'b1;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", valid_o); end
    total++; if (am_v_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_am got=%b exp=0", am_v_o); end
    total++; if (deskew_lock_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_lock got=%b exp=0", deskew_lock_o); end
    total++; if (skew_err_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got=%b exp=0", skew_err_o); end
    total++; if (skew_o !== 20'h0) begin bad++; $display("[TB] FAIL rst_skew got=%h exp=0", skew_o); end
    total++; if (data_o !== 264'h0) begin bad++; $display("[TB] FAIL rst_data got=%h exp=0", data_o); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_zero_skew();
    int c = 0;
    int errs = 0;
    int amCnt = 0;
    offA = '{0, 0, 0, 0}; offB = offA; switchV = 0; computeD(1'b1);
    doReset();
    while (!deskew_lock_o && c < 200) begin applyStimulus(1'b1); if (skew_err_o) errs++; c++; end
    total++; if (deskew_lock_o !== 1'b1) begin bad++; $display("[TB] FAIL zero_lock got=%b exp=1", deskew_lock_o); end
    total++; if (vcnt - 1 !== 20) begin bad++; $display("[TB] FAIL zero_lock_idx got=%0d exp=20", vcnt - 1); end
    total++; if (am_v_o !== 1'b1) begin bad++; $display("[TB] FAIL zero_lock_am got=%b exp=1", am_v_o); end
    total++; if (skew_o !== expSkew()) begin bad++; $display("[TB] FAIL zero_skew got=%h exp=%h", skew_o, expSkew()); end
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL zero_search_err got=%0d exp=0", errs); end
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'b1);
      if (am_v_o) amCnt++;
      total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL zero_valid v=%0d got=%b exp=1", vcnt - 1, valid_o); end
      total++; if (data_o !== expData()) begin bad++; $display("[TB] FAIL zero_data v=%0d got=%h exp=%h", vcnt - 1, data_o, expData()); end
      total++; if (am_v_o !== expAm()) begin bad++; $display("[TB] FAIL zero_am v=%0d got=%b exp=%b", vcnt - 1, am_v_o, expAm()); end
      total++; if (skew_err_o !== 1'b0) begin bad++; $display("[TB] FAIL zero_err v=%0d got=%b exp=0", vcnt - 1, skew_err_o); end
    end
    total++; if (amCnt !== 3) begin bad++; $display("[TB] FAIL zero_am_count got=%0d exp=3", amCnt); end
  endtask

  task automatic test_staggered();
    int c = 0;
    offA = '{0, 3, 7, 1}; offB = offA; switchV = 0; computeD(1'b1);
    doReset();
    while (!deskew_lock_o && c < 200) begin applyStimulus(1'b1); c++; end
    total++; if (vcnt - 1 !== 27) begin bad++; $display("[TB] FAIL stag_lock_idx got=%0d exp=27", vcnt - 1); end
    total++; if (skew_o !== {5'd6, 5'd0, 5'd4, 5'd7}) begin bad++; $display("[TB] FAIL stag_skew got=%h exp=%h", skew_o, {5'd6, 5'd0, 5'd4, 5'd7}); end
    total++; if (valid_o !== 1'b1 || am_v_o !== 1'b1) begin bad++; $display("[TB] FAIL stag_first got=%b%b exp=11", valid_o, am_v_o); end
    for (int k = 0; k < 150; k++) begin
      applyStimulus(1'b1);
      total++; if (data_o !== expData()) begin bad++; $display("[TB] FAIL stag_data v=%0d got=%h exp=%h", vcnt - 1, data_o, expData()); end
      total++; if (am_v_o !== expAm()) begin bad++; $display("[TB] FAIL stag_am v=%0d got=%b exp=%b", vcnt - 1, am_v_o, expAm()); end
      total++; if (skew_err_o !== 1'b0) begin bad++; $display("[TB] FAIL stag_err v=%0d got=%b exp=0", vcnt - 1, skew_err_o); end
    end
  endtask

  task automatic test_overflow();
    int c = 0;
    int errs = 0;
    offA = '{0, 0, 27, 0}; offB = '{2, 0, 5, 1}; switchV = 48; computeD(1'b1);
    doReset();
    while (!deskew_lock_o && c < 250) begin applyStimulus(1'b1); if (skew_err_o) errs++; c++; end
    total++; if (errs !== 1) begin bad++; $display("[TB] FAIL ovf_err_count got=%0d exp=1", errs); end
    total++; if (vcnt - 1 !== 89) begin bad++; $display("[TB] FAIL ovf_lock_idx got=%0d exp=89", vcnt - 1); end
    total++; if (skew_o !== {5'd4, 5'd0, 5'd5, 5'd3}) begin bad++; $display("[TB] FAIL ovf_skew got=%h exp=%h", skew_o, {5'd4, 5'd0, 5'd5, 5'd3}); end
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'b1);
      total++; if (data_o !== expData()) begin bad++; $display("[TB] FAIL ovf_data v=%0d got=%h exp=%h", vcnt - 1, data_o, expData()); end
      total++; if (am_v_o !== expAm()) begin bad++; $display("[TB] FAIL ovf_am v=%0d got=%b exp=%b", vcnt - 1, am_v_o, expAm()); end
    end
  endtask

  task automatic test_valid_gaps();
    int c = 0;
    bit vld;
    offA = '{0, 3, 7, 1}; offB = offA; switchV = 0; computeD(1'b1);
    doReset();
    while (!deskew_lock_o && c < 200) begin applyStimulus((c % 66) != 23); c++; end
    total++; if (vcnt - 1 !== 27) begin bad++; $display("[TB] FAIL gap_lock_idx got=%0d exp=27", vcnt - 1); end
    total++; if (skew_o !== {5'd6, 5'd0, 5'd4, 5'd7}) begin bad++; $display("[TB] FAIL gap_skew got=%h exp=%h", skew_o, {5'd6, 5'd0, 5'd4, 5'd7}); end
    for (int k = 0; k < 200; k++) begin
      vld = (((c + 20) % 66) != 0) && ($urandom_range(0, 65) != 0);
      applyStimulus(vld);
      c++;
      total++; if (valid_o !== vld) begin bad++; $display("[TB] FAIL gap_valid c=%0d got=%b exp=%b", c, valid_o, vld); end
      if (vld) begin
        total++; if (data_o !== expData()) begin bad++; $display("[TB] FAIL gap_data v=%0d got=%h exp=%h", vcnt - 1, data_o, expData()); end
      end
      total++; if (am_v_o !== (vld & expAm())) begin bad++; $display("[TB] FAIL gap_am v=%0d got=%b exp=%b", vcnt - 1, am_v_o, vld & expAm()); end
      total++; if (deskew_lock_o !== 1'b1) begin bad++; $display("[TB] FAIL gap_lock v=%0d got=%b exp=1", vcnt - 1, deskew_lock_o); end
    end
  endtask

  task automatic test_misalign();
    int c = 0;
    int errs = 0;
    offA = '{0, 3, 7, 1}; offB = '{0, 4, 7, 1}; switchV = 60; computeD(1'b0);
    doReset();
    while (!deskew_lock_o && c < 200) begin applyStimulus(1'b1); c++; end
    total++; if (vcnt - 1 !== 27) begin bad++; $display("[TB] FAIL mis_lock_idx got=%0d exp=27", vcnt - 1); end
    while (vcnt < 92) begin
      applyStimulus(1'b1);
      total++; if (data_o !== expData()) begin bad++; $display("[TB] FAIL mis_data v=%0d got=%h exp=%h", vcnt - 1, data_o, expData()); end
      total++; if (am_v_o !== expAm()) begin bad++; $display("[TB] FAIL mis_am v=%0d got=%b exp=%b", vcnt - 1, am_v_o, expAm()); end
    end
    applyStimulus(1'b1);
    total++; if (skew_err_o !== 1'b1) begin bad++; $display("[TB] FAIL mis_err_pulse got=%b exp=1", skew_err_o); end
    total++; if (deskew_lock_o !== 1'b0) begin bad++; $display("[TB] FAIL mis_lock_drop got=%b exp=0", deskew_lock_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL mis_valid got=%b exp=0", valid_o); end
    applyStimulus(1'b1);
    total++; if (skew_err_o !== 1'b0) begin bad++; $display("[TB] FAIL mis_err_width got=%b exp=0", skew_err_o); end
    computeD(1'b1);
    c = 0;
    while (!deskew_lock_o && c < 200) begin applyStimulus(1'b1); if (skew_err_o) errs++; c++; end
    total++; if (vcnt - 1 !== 155) begin bad++; $display("[TB] FAIL mis_relock_idx got=%0d exp=155", vcnt - 1); end
    total++; if (errs !== 0) begin bad++; $display("[TB] FAIL mis_search_err got=%0d exp=0", errs); end
    total++; if (skew_o !== {5'd6, 5'd0, 5'd3, 5'd7}) begin bad++; $display("[TB] FAIL mis_skew got=%h exp=%h", skew_o, {5'd6, 5'd0, 5'd3, 5'd7}); end
    for (int k = 0; k < 70; k++) begin
      applyStimulus(1'b1);
      total++; if (data_o !== expData()) begin bad++; $display("[TB] FAIL mis_relock_data v=%0d got=%h exp=%h", vcnt - 1, data_o, expData()); end
      total++; if (am_v_o !== expAm()) begin bad++; $display("[TB] FAIL mis_relock_am v=%0d got=%b exp=%b", vcnt - 1, am_v_o, expAm()); end
    end
  endtask

  task automatic test_lock_loss();
    int c = 0;
    offA = '{0, 3, 7, 1}; offB = offA; switchV = 0; computeD(1'b1);
    doReset();
    while (!deskew_lock_o && c < 200) begin applyStimulus(1'b1); c++; end
    repeat (5) applyStimulus(1'b1);
    total++; if (deskew_lock_o !== 1'b1) begin bad++; $display("[TB] FAIL loss_pre_lock got=%b exp=1", deskew_lock_o); end
    am_lock_i[3] = 1'b0;
    applyStimulus(1'b1);
    total++; if (deskew_lock_o !== 1'b0) begin bad++; $display("[TB] FAIL loss_lock got=%b exp=0", deskew_lock_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL loss_valid got=%b exp=0", valid_o); end
    total++; if (am_v_o !== 1'b0) begin bad++; $display("[TB] FAIL loss_am got=%b exp=0", am_v_o); end
    am_lock_i = 4'hF;
    repeat (10) applyStimulus(1'b1);
    #2 reset = 1'b1;
    #1;
    total++; if (skew_o !== 20'h0) begin bad++; $display("[TB] FAIL areset_skew got=%h exp=0", skew_o); end
    total++; if (data_o !== 264'h0) begin bad++; $display("[TB] FAIL areset_data got=%h exp=0", data_o); end
    total++; if ({valid_o, am_v_o, deskew_lock_o, skew_err_o} !== 4'b0) begin bad++; $display("[TB] FAIL areset_ctrl got=%b exp=0000", {valid_o, am_v_o, deskew_lock_o, skew_err_o}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    am_lock_i = 4'h0;
    valid_i = 1'b0;
    am_v_i = '0;
    data_i = '0;
    vcnt = 0;
    switchV = 0;
    test_reset();
    test_zero_skew();
    test_staggered();
    test_overflow();
    test_valid_gaps();
    test_misalign();
    test_lock_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
